// File: rtl/bus_arbiter2.sv
// Two-requester round-robin arbiter for a single shared memory port (fetch vs. load/store).
// Optional BUSY watchdog abort enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter2 #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    input  logic             we0,
    input  logic             we1,
    output logic             ack0,
    output logic             ack1,
    output logic             err,
    output logic [WIDTH-1:0] rdata,
    output logic             mem_sel,
    output logic             mem_en,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_rdy
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t state_reg;
    logic   last_gnt_reg;
    logic   win;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_reg;
    logic             err_reg;
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        win = req1;
        if (req0 && req1)
            win = ~last_gnt_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            last_gnt_reg <= 1'b1;
            mem_sel      <= 1'b0;
            mem_en       <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            rdata        <= '0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_reg      <= '0;
            err_reg      <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req0 || req1) begin
                        mem_sel      <= win;
                        mem_en       <= 1'b1;
                        mem_we       <= win ? we1 : we0;
                        mem_addr     <= win ? addr1 : addr0;
                        mem_wdata    <= win ? wdata1 : wdata0;
                        last_gnt_reg <= win;
                        state_reg    <= BUSY;
`ifdef ARB_TIMEOUT_EN
                        cnt_reg      <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (mem_rdy) begin
                        mem_en    <= 1'b0;
                        ack0      <= ~mem_sel;
                        ack1      <= mem_sel;
                        if (!mem_we)
                            rdata <= mem_rdata;
                        state_reg <= RESP;
                    end
`ifdef ARB_TIMEOUT_EN
                    // mem_rdy on the final counted edge still wins over the abort.
                    else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        mem_en    <= 1'b0;
                        ack0      <= ~mem_sel;
                        ack1      <= mem_sel;
                        err_reg   <= 1'b1;
                        rdata     <= '0;
                        state_reg <= RESP;
                    end else begin
                        cnt_reg   <= cnt_reg + 1'b1;
                    end
`endif
                end
                RESP: begin
                    ack0      <= 1'b0;
                    ack1      <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    err_reg   <= 1'b0;
`endif
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Directed bench for bus_arbiter2: table of single transactions plus hand-written
// sequences for round-robin hold, reset during BUSY and the BUSY watchdog.
module tb_bus_arbiter2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1, mem_rdy;
    logic [31:0] addr0, addr1, wdata0, wdata1, mem_rdata;
    logic        ack0, ack1, err, mem_sel, mem_en, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;

    int errors = 0;
    int checks = 0;

    bus_arbiter2 #(.WIDTH(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1),
        .ack0(ack0), .ack1(ack1), .err(err), .rdata(rdata),
        .mem_sel(mem_sel), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [31:0] a0, a1, d0, d1, mrd;
        logic        esel, ewe;
        logic [31:0] eaddr, ewdata, erdata;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int n;
        int seen;
        logic got;

        // Expected winners assume last_gnt=1 out of reset and carry across rows.
        //           r0    r1    w0    w1    a0            a1            d0            d1            mrd           sel   we    eaddr         ewdata        erdata
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00000040, 32'h0,        32'h0,        32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 32'h00000040, 32'h0,        32'hDEADBEEF};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        32'h00000100, 32'h0,        32'h12345678, 32'hFFFF0000, 1'b1, 1'b1, 32'h00000100, 32'h12345678, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h00000080, 32'h00000104, 32'h0,        32'h55555555, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h00000080, 32'h0,        32'hA5A5A5A5};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h00000084, 32'h00000200, 32'h77777777, 32'h0,        32'h0BADF00D, 1'b1, 1'b0, 32'h00000200, 32'h0,        32'h0BADF00D};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000000C, 32'h00000204, 32'hCAFEBABE, 32'h0,        32'h99999999, 1'b0, 1'b1, 32'h0000000C, 32'hCAFEBABE, 32'h0BADF00D};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00000044, 32'h00000208, 32'h0,        32'h0,        32'h11111111, 1'b0, 1'b0, 32'h00000044, 32'h0,        32'h11111111};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00000048, 32'h0000020C, 32'h0,        32'h0,        32'h22222222, 1'b1, 1'b0, 32'h0000020C, 32'h0,        32'h22222222};

        req0 = 0; req1 = 0; we0 = 0; we1 = 0; mem_rdy = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; mem_rdata = 0;
        rst_n = 1'b0;
        #12;
        check("reset_mem_en", {31'b0, mem_en}, 32'd0);
        check("reset_mem_we", {31'b0, mem_we}, 32'd0);
        check("reset_acks",   {29'b0, ack0, ack1, err}, 32'd0);
        check("reset_sel",    {31'b0, mem_sel}, 32'd0);
        check("reset_addr",   mem_addr, 32'd0);
        check("reset_wdata",  mem_wdata, 32'd0);
        check("reset_rdata",  rdata, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Table: one full grant/complete/resp transaction per row.
        for (int i = 0; i < 7; i++) begin
            req0 = vecs[i].r0; req1 = vecs[i].r1; we0 = vecs[i].w0; we1 = vecs[i].w1;
            addr0 = vecs[i].a0; addr1 = vecs[i].a1; wdata0 = vecs[i].d0; wdata1 = vecs[i].d1;
            mem_rdata = vecs[i].mrd; mem_rdy = 1'b0;
            step();
            check("grant_en",    {31'b0, mem_en}, 32'd1);
            check("grant_sel",   {31'b0, mem_sel}, {31'b0, vecs[i].esel});
            check("grant_we",    {31'b0, mem_we}, {31'b0, vecs[i].ewe});
            check("grant_addr",  mem_addr, vecs[i].eaddr);
            check("grant_wdata", mem_wdata, vecs[i].ewdata);
            check("busy_noack",  {30'b0, ack0, ack1}, 32'd0);
            req0 = 0; req1 = 0; mem_rdy = 1'b1;
            step();
            check("done_ack",   {30'b0, ack0, ack1}, vecs[i].esel ? 32'd1 : 32'd2);
            check("done_rdata", rdata, vecs[i].erdata);
            check("done_en",    {31'b0, mem_en}, 32'd0);
            check("done_err",   {31'b0, err}, 32'd0);
            mem_rdy = 1'b0;
            step();
            check("resp_end_ack", {30'b0, ack0, ack1}, 32'd0);
            check("idle_sel_hold", {31'b0, mem_sel}, {31'b0, vecs[i].esel});
            $display("vec %0d: sel=%0d we=%0d addr=%h rdata=%h", i, mem_sel, mem_we, mem_addr, rdata);
        end

        // BUSY holds mem_* stable while requester inputs change.
        req0 = 1; we0 = 0; addr0 = 32'h00000500; mem_rdata = 32'h13572468;
        step();
        req0 = 0; req1 = 1; addr0 = 32'hFFFFFFFF; addr1 = 32'hEEEEEEEE; we1 = 1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold_addr", mem_addr, 32'h00000500);
            check("hold_en_sel_we", {29'b0, mem_en, mem_sel, mem_we}, 32'd4);
            check("hold_noack", {30'b0, ack0, ack1}, 32'd0);
        end
        req1 = 0; mem_rdy = 1;
        step();
        check("hold_done_ack", {30'b0, ack0, ack1}, 32'd2);
        check("hold_done_rdata", rdata, 32'h13572468);
        mem_rdy = 0;
        step();
        $display("hold: addr=%h rdata=%h", mem_addr, rdata);

        // Both requests held high from reset: strict alternation 0,1,0,1.
        do_reset();
        req0 = 1; req1 = 1; we0 = 0; we1 = 0; mem_rdy = 1;
        seen = 0;
        for (int c = 0; c < 40 && seen < 4; c++) begin
            step();
            if (ack0 || ack1) begin
                check("alt_ack1", {31'b0, ack1}, {31'b0, seen[0]});
                check("alt_ack0", {31'b0, ack0}, {31'b0, ~seen[0]});
                check("alt_sel",  {31'b0, mem_sel}, {31'b0, seen[0]});
                $display("alt %0d: ack0=%0d ack1=%0d sel=%0d", seen, ack0, ack1, mem_sel);
                seen++;
            end
        end
        check("alt_count", seen, 32'd4);
        req0 = 0; req1 = 0; mem_rdy = 0;
        step(); step(); step();

        // Reset in the third BUSY cycle aborts silently; requester 0 wins the first tie after.
        do_reset();
        req1 = 1; we1 = 0; addr1 = 32'h00000300;
        step();
        check("rb_grant_sel", {31'b0, mem_sel}, 32'd1);
        req1 = 0;
        step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        check("rb_en_cleared", {31'b0, mem_en}, 32'd0);
        check("rb_no_ack", {30'b0, ack0, ack1}, 32'd0);
        check("rb_sel_cleared", {31'b0, mem_sel}, 32'd0);
        req0 = 1; req1 = 1;
        step();
        check("rb_in_reset_noack", {30'b0, ack0, ack1}, 32'd0);
        rst_n = 1'b1;
        step();
        check("rb_first_sel", {31'b0, mem_sel}, 32'd0);
        check("rb_first_en", {31'b0, mem_en}, 32'd1);
        req0 = 0; req1 = 0; mem_rdy = 1;
        step();
        check("rb_first_ack", {30'b0, ack0, ack1}, 32'd2);
        mem_rdy = 0;
        step();
        $display("reset-in-busy: first grant sel=0 after release");

`ifdef ARB_TIMEOUT_EN
        // Watchdog abort after 15 BUSY edges without mem_rdy.
        req0 = 1; we0 = 0; addr0 = 32'h00000600; mem_rdata = 32'h44444444;
        step();
        req0 = 0;
        n = 0; got = 1'b0;
        for (int c = 1; c <= 40 && !got; c++) begin
            step();
            if (ack0 || ack1) begin got = 1'b1; n = c; end
        end
        check("to_seen", {31'b0, got}, 32'd1);
        check("to_edges", n, 32'd15);
        check("to_err", {31'b0, err}, 32'd1);
        check("to_rdata", rdata, 32'd0);
        check("to_en", {31'b0, mem_en}, 32'd0);
        step();
        check("to_err_clear", {29'b0, ack0, ack1, err}, 32'd0);
        $display("timeout: ack after %0d BUSY edges", n);

        // mem_rdy on the 15th edge completes normally.
        req0 = 1;
        step();
        req0 = 0;
        for (int c = 0; c < 14; c++) step();
        check("to_edge_noack", {30'b0, ack0, ack1}, 32'd0);
        mem_rdy = 1;
        step();
        check("to_edge_ack", {31'b0, ack0}, 32'd1);
        check("to_edge_err", {31'b0, err}, 32'd0);
        check("to_edge_rdata", rdata, 32'h44444444);
        mem_rdy = 0;
        step();
        $display("timeout edge: normal completion");
`else
        // Without the watchdog BUSY waits indefinitely.
        req0 = 1; we0 = 0; addr0 = 32'h00000600; mem_rdata = 32'h44444444;
        step();
        req0 = 0;
        got = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (ack0 || ack1 || err) got = 1'b1;
        end
        check("nto_no_ack", {31'b0, got}, 32'd0);
        check("nto_en_held", {31'b0, mem_en}, 32'd1);
        mem_rdy = 1;
        step();
        check("nto_ack", {30'b0, ack0, ack1}, 32'd2);
        check("nto_err", {31'b0, err}, 32'd0);
        check("nto_rdata", rdata, 32'h44444444);
        mem_rdy = 0;
        step();
        $display("no-timeout: waited 30 cycles, then completed");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
